// File: rtl/stage_id_pipe.sv
// stage_id_pipe: RV32I decode stage with forwarding, load-use stall, in-ID branch resolution and a registered ID/EX boundary
module stage_id_pipe #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [31:0]              inst_i,
    input  logic                     flush_i,
    output logic [4:0]               reg1_addr_o,
    output logic [4:0]               reg2_addr_o,
    input  logic [XLEN-1:0]          data1_i,
    input  logic [XLEN-1:0]          data2_i,
    input  logic [FWD_SRCS-1:0]      fwd_wreg_i,
    input  logic [5*FWD_SRCS-1:0]    fwd_wd_i,
    input  logic [XLEN*FWD_SRCS-1:0] fwd_wdata_i,
    input  logic [FWD_SRCS-1:0]      fwd_pending_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [6:0]               opcode_o,
    output logic [2:0]               func3_o,
    output logic [6:0]               func7_o,
    output logic [4:0]               wd_o,
    output logic                     wreg_o,
    output logic [XLEN-1:0]          op1_o,
    output logic [XLEN-1:0]          op2_o,
    output logic [XLEN-1:0]          ls_offset_o,
    output logic                     illegal_o,
    output logic                     redirect_o,
    output logic [XLEN-1:0]          redirect_pc_o
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign rs1 = inst_i[19:15];
    assign rs2 = inst_i[24:20];
    assign rd  = inst_i[11:7];
    assign reg1_addr_o = rs1;
    assign reg2_addr_o = rs2;

    logic [XLEN-1:0] r1, r2;
    logic            p1, p2;

    // operand values: x0 reads 0, otherwise the youngest matching forwarding source beats the regfile
    always_comb begin
        r1 = data1_i;
        r2 = data2_i;
        p1 = 1'b0;
        p2 = 1'b0;
        for (int k = FWD_SRCS - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == rs1) begin
                r1 = fwd_wdata_i[XLEN*k +: XLEN];
                p1 = fwd_pending_i[k];
            end
            if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == rs2) begin
                r2 = fwd_wdata_i[XLEN*k +: XLEN];
                p2 = fwd_pending_i[k];
            end
        end
        if (rs1 == 5'd0) begin
            r1 = '0;
            p1 = 1'b0;
        end
        if (rs2 == 5'd0) begin
            r2 = '0;
            p2 = 1'b0;
        end
    end

    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_reg;
    assign is_lui   = opc == OP_LUI;
    assign is_auipc = opc == OP_AUIPC;
    assign is_jal   = opc == OP_JAL;
    assign is_jalr  = opc == OP_JALR;
    assign is_br    = opc == OP_BR;
    assign is_ld    = opc == OP_LD;
    assign is_st    = opc == OP_ST;
    assign is_imm   = opc == OP_IMM;
    assign is_reg   = opc == OP_REG;

    logic legal, use1, use2, wr, hazard;
    assign legal  = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_imm | is_reg;
    assign use1   = is_jalr | is_br | is_ld | is_st | is_imm | is_reg;
    assign use2   = is_br | is_st | is_reg;
    assign wr     = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_imm | is_reg;
    assign hazard = (use1 && p1) || (use2 && p2);

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    assign imm_i = XLEN'($signed(inst_i[31:20]));
    assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign shamt = XLEN'(inst_i[24:20]);

    logic eq, lt, ltu, br_take, take;
    assign eq      = r1 == r2;
    assign lt      = $signed(r1) < $signed(r2);
    assign ltu     = r1 < r2;
    assign br_take = f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (f3[1] ? 1'b0 : eq ^ f3[0]);
    assign take    = is_jal | is_jalr | (is_br && br_take);

    logic [XLEN-1:0] target, op1, op2, ls;
    assign target = is_jalr ? (r1 + imm_i) & ~XLEN'(1) : pc_i + (is_jal ? imm_j : imm_b);
    assign op1 = (is_auipc | is_jal | is_jalr) ? pc_i : use1 ? r1 : '0;
    assign op2 = (is_jal | is_jalr) ? XLEN'(4) :
                 (is_reg | is_br | is_st) ? r2 :
                 is_ld ? imm_i :
                 is_imm ? (f3[1:0] == 2'b01 ? shamt : imm_i) :
                 (is_lui | is_auipc) ? imm_u : '0;
    assign ls  = is_ld ? imm_i : is_st ? imm_s : '0;

    logic shadow, acc, load;
    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
    assign acc  = in_valid_i && in_ready_o;
    assign load = acc && !shadow && |inst_i;

    // valid, redirect pulse and wrong-path shadow; a shadowed or all-zero beat is consumed but never issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o   <= 1'b0;
            redirect_o    <= 1'b0;
            shadow        <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            out_valid_o <= !flush_i && (acc ? load : out_valid_o && !out_ready_i);
            redirect_o  <= load && take;
            shadow      <= load && take;
            if (load && take) redirect_pc_o <= target;
        end
    end

    // ID/EX payload, captured only for issued instructions and held under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_o    <= '0;
            func3_o     <= '0;
            func7_o     <= '0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            op1_o       <= '0;
            op2_o       <= '0;
            ls_offset_o <= '0;
            illegal_o   <= 1'b0;
        end else if (load) begin
            opcode_o    <= opc;
            func3_o     <= f3;
            func7_o     <= inst_i[31:25];
            wd_o        <= wr ? rd : 5'd0;
            wreg_o      <= wr;
            op1_o       <= op1;
            op2_o       <= op2;
            ls_offset_o <= ls;
            illegal_o   <= !legal;
        end
    end
endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe: directed and randomized check of stage_id_pipe against a behavioural decode model
module tb_stage_id_pipe;
    localparam int XLEN = 32;
    localparam int NF   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid, flush, out_ready;
    logic [31:0]     pc, inst, d1, d2;
    logic [NF-1:0]   fw_wreg, fw_pend;
    logic [5*NF-1:0] fw_wd;
    logic [32*NF-1:0] fw_wdata;

    logic        in_ready_o, out_valid_o, wreg_o, illegal_o, redirect_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
    logic [6:0]  opcode_o, func7_o;
    logic [2:0]  func3_o;
    logic [31:0] op1_o, op2_o, ls_offset_o, redirect_pc_o;

    stage_id_pipe #(.XLEN(XLEN), .FWD_SRCS(NF)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .pc_i(pc), .inst_i(inst), .flush_i(flush),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .data1_i(d1), .data2_i(d2),
        .fwd_wreg_i(fw_wreg), .fwd_wd_i(fw_wd), .fwd_wdata_i(fw_wdata), .fwd_pending_i(fw_pend),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .opcode_o(opcode_o), .func3_o(func3_o), .func7_o(func7_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .op1_o(op1_o), .op2_o(op2_o),
        .ls_offset_o(ls_offset_o), .illegal_o(illegal_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    typedef struct packed {
        logic        ill;
        logic        wr;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  wd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] ls;
    } pay_t;

    logic        m_v = 1'b0, m_sh = 1'b0, m_rd = 1'b0;
    logic [31:0] m_rpc = '0;
    pay_t        m_p = '0;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] src(input logic [4:0] a, input logic [31:0] rf, output logic pend);
        pend = 1'b0;
        if (a == 5'd0) return 32'd0;
        for (int k = 0; k < NF; k++)
            if (fw_wreg[k] && fw_wd[5*k +: 5] == a) begin
                pend = fw_pend[k];
                return fw_wdata[32*k +: 32];
            end
        return rf;
    endfunction

    task automatic ref_id(output logic rdy, output logic go, output pay_t p, output logic take, output logic [31:0] tgt);
        logic [31:0] a, b, ii, is, ib, iu, ij;
        logic pa, pb, ua, ub;
        logic [2:0] f3;
        a  = src(inst[19:15], d1, pa);
        b  = src(inst[24:20], d2, pb);
        f3 = inst[14:12];
        ii = 32'($signed(inst[31:20]));
        is = 32'($signed({inst[31:25], inst[11:7]}));
        ib = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        iu = {inst[31:12], 12'b0};
        ij = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        p = '0;
        p.opc = inst[6:0];
        p.f3  = f3;
        p.f7  = inst[31:25];
        ua = 1'b0; ub = 1'b0; take = 1'b0; tgt = '0;
        case (inst[6:0])
            7'h37: begin p.wr = 1; p.op2 = iu; end
            7'h17: begin p.wr = 1; p.op1 = pc; p.op2 = iu; end
            7'h6f: begin p.wr = 1; p.op1 = pc; p.op2 = 32'd4; take = 1; tgt = pc + ij; end
            7'h67: begin ua = 1; p.wr = 1; p.op1 = pc; p.op2 = 32'd4; take = 1; tgt = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                ua = 1; ub = 1; p.op1 = a; p.op2 = b; tgt = pc + ib;
                case (f3)
                    3'd0: take = a == b;
                    3'd1: take = a != b;
                    3'd4: take = $signed(a) < $signed(b);
                    3'd5: take = $signed(a) >= $signed(b);
                    3'd6: take = a < b;
                    3'd7: take = a >= b;
                    default: take = 0;
                endcase
            end
            7'h03: begin ua = 1; p.wr = 1; p.op1 = a; p.op2 = ii; p.ls = ii; end
            7'h23: begin ua = 1; ub = 1; p.op1 = a; p.op2 = b; p.ls = is; end
            7'h13: begin ua = 1; p.wr = 1; p.op1 = a; p.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, inst[24:20]} : ii; end
            7'h33: begin ua = 1; ub = 1; p.wr = 1; p.op1 = a; p.op2 = b; end
            default: p.ill = 1;
        endcase
        if (p.wr) p.wd = inst[11:7];
        rdy = (!m_v || out_ready) && !((ua && pa) || (ub && pb)) && !flush;
        go  = in_valid && rdy;
    endtask

    task automatic check_out();
        chk("out_valid", out_valid_o, m_v);
        chk("redirect", redirect_o, m_rd);
        if (m_rd) chk("redirect_pc", redirect_pc_o, m_rpc);
        if (m_v) begin
            chk("opcode", opcode_o, m_p.opc);
            chk("func3", func3_o, m_p.f3);
            chk("func7", func7_o, m_p.f7);
            chk("wd", wd_o, m_p.wd);
            chk("wreg", wreg_o, m_p.wr);
            chk("op1", op1_o, m_p.op1);
            chk("op2", op2_o, m_p.op2);
            chk("ls_offset", ls_offset_o, m_p.ls);
            chk("illegal", illegal_o, m_p.ill);
        end
    endtask

    task automatic step();
        logic rdy, go, take;
        pay_t p;
        logic [31:0] tgt;
        #1;
        ref_id(rdy, go, p, take, tgt);
        chk("in_ready", in_ready_o, rdy);
        chk("reg1_addr", reg1_addr_o, inst[19:15]);
        if (go && !m_sh && inst != 0) begin
            m_v = 1; m_p = p; m_rd = take; m_sh = take;
            if (take) m_rpc = tgt;
        end else begin
            m_v = !flush && !go && m_v && !out_ready;
            m_rd = 0; m_sh = 0;
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle();
        in_valid = 0; inst = '0; flush = 0; out_ready = 1;
        fw_wreg = '0; fw_pend = '0; fw_wd = '0; fw_wdata = '0;
        d1 = '0; d2 = '0; pc = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        #1;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_redirect", redirect_o, 0);
        chk("rst_rpc", redirect_pc_o, 0);
        chk("rst_op1", op1_o, 0);
        chk("rst_op2", op2_o, 0);
        chk("rst_ls", ls_offset_o, 0);
        chk("rst_opcode", opcode_o, 0);
        chk("rst_f3f7", {func3_o, func7_o}, 0);
        chk("rst_wd", {wreg_o, wd_o}, 0);
        chk("rst_illegal", illegal_o, 0);
        m_v = 0; m_sh = 0; m_rd = 0; m_p = '0; m_rpc = '0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, s2, s1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, s1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3);
        return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f};

    initial begin
        idle();
        #1;
        do_reset();

        fw_wreg = 2'b11; fw_wd = {5'd5, 5'd5}; fw_wdata = {32'h22, 32'h11};
        d1 = 32'hdead; inst = enc_r(5'd0, 5'd5, 3'd0, 5'd1); in_valid = 1;
        step();
        chk("fwd_prio_op1", op1_o, 32'h11);
        chk("fwd_prio_op2", op2_o, 32'h0);

        idle(); step();
        fw_wreg = 2'b01; fw_wd = {5'd0, 5'd5}; fw_wdata = {32'h0, 32'h77}; fw_pend = 2'b01;
        inst = enc_i(12'd3, 5'd5, 3'd0, 5'd1, 7'h13); in_valid = 1;
        step();
        chk("loaduse_stall", in_ready_o, 0);
        fw_pend = 2'b00;
        step();
        chk("loaduse_op1", op1_o, 32'h77);
        chk("loaduse_op2", op2_o, 32'd3);

        idle();
        pc = 32'h100; d1 = 32'hFFFF_FFFF; d2 = 32'd1;
        inst = enc_b(13'd16, 5'd7, 5'd6, 3'b100); in_valid = 1;
        step();
        chk("blt_redirect", redirect_o, 1);
        chk("blt_target", redirect_pc_o, 32'h110);
        inst = enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13); pc = 32'h104;
        step();
        chk("shadow_drop", out_valid_o, 0);
        chk("pulse_once", redirect_o, 0);

        pc = 32'h100; inst = enc_b(13'd16, 5'd7, 5'd6, 3'b110);
        step();
        chk("bltu_redirect", redirect_o, 0);
        chk("bltu_valid", out_valid_o, 1);

        pc = 32'h200; d1 = 32'h1003; inst = enc_i(12'd0, 5'd6, 3'd0, 5'd1, 7'h67);
        step();
        chk("jalr_target", redirect_pc_o, 32'h1002);
        chk("jalr_op1", op1_o, 32'h200);
        chk("jalr_op2", op2_o, 32'd4);
        chk("jalr_wreg", wreg_o, 1);
        idle(); step();

        d1 = 32'd5; d2 = 32'd6; inst = enc_r(5'd2, 5'd1, 3'd0, 5'd3); in_valid = 1;
        step();
        out_ready = 0; inst = enc_i(12'd1, 5'd1, 3'd0, 5'd4, 7'h13);
        repeat (3) begin
            step();
            chk("bp_hold_op1", op1_o, 32'd5);
            chk("bp_ready", in_ready_o, 0);
        end
        flush = 1;
        step();
        chk("flush_valid", out_valid_o, 0);
        flush = 0; out_ready = 1;
        step();
        do_reset();

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            pc        = $urandom & 32'hFFFF_FFFC;
            inst      = $urandom;
            inst[6:0] = ops[$urandom_range(0, 9)];
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) inst = '0;
            d1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            d2 = ($urandom_range(0, 2) == 0) ? d1 : $urandom;
            fw_wreg  = 2'($urandom_range(0, 3));
            fw_wd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fw_wdata = {$urandom, $urandom};
            fw_pend  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
